// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between the pooling channels and the round-robin SRAM write arbiter.
// Handshake: a channel push happens on a rising edge where ch_valid[i] && ch_ready[i]; ch_ready[i] depends only on registered state.
interface wb_rr_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 13,
    parameter int MEM_W  = 16,
    parameter int ADDR_W = 10
);
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     sign_ext;
    logic                     clr_ovf;
    logic                     sram_wr_en;
    logic [ADDR_W-1:0]        sram_wr_addr;
    logic [MEM_W-1:0]         sram_wr_data;
    logic [NUM_CH-1:0]        ovf;
    logic                     idle;

    modport master (
        output ch_valid, ch_data, ch_addr, sign_ext, clr_ovf,
        input  ch_ready, sram_wr_en, sram_wr_addr, sram_wr_data, ovf, idle
    );

    modport slave (
        input  ch_valid, ch_data, ch_addr, sign_ext, clr_ovf,
        output ch_ready, sram_wr_en, sram_wr_addr, sram_wr_data, ovf, idle
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Per-channel {addr, data} FIFOs drained one entry per cycle, round-robin, into a registered SRAM write port.
module wb_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 13,
    parameter int MEM_W  = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input logic            clk,
    input logic            rstn,
    wb_rr_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EXT_W = MEM_W - DATA_W;

    logic [ADDR_W-1:0] addr_mem_q [NUM_CH][DEPTH];
    logic [DATA_W-1:0] data_mem_q [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q   [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q   [NUM_CH];
    logic [CNT_W-1:0]  count_q    [NUM_CH];
    logic [CNT_W-1:0]  count_d    [NUM_CH];
    logic [CH_W-1:0]   prio_q;
    logic [CH_W-1:0]   prio_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [MEM_W-1:0]  wr_data_q;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              grant_vld;
    logic [CH_W-1:0]   grant_idx;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [MEM_W-1:0]  ext_data;
    logic              busy;
    int                cand;

    // A full FIFO refuses a push even if it is popped on the same edge.
    always_comb begin
        busy = wr_en_q;
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]    = (count_q[i] == CNT_W'(DEPTH));
            push[i]    = bus.ch_valid[i] & ~full[i];
            pop[i]     = grant_vld && (grant_idx == CH_W'(i));
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            ovf_d[i]   = (ovf_q[i] & ~bus.clr_ovf) | (bus.ch_valid[i] & full[i]);
            busy       = busy | (count_q[i] != '0);
        end
    end

    // First non-empty channel scanning upward from prio_q, wrapping at NUM_CH.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = int'(prio_q) + i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (!grant_vld && (count_q[cand] != '0)) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(cand);
            end
        end
    end

    always_comb begin
        head_addr = addr_mem_q[grant_idx][rd_ptr_q[grant_idx]];
        head_data = data_mem_q[grant_idx][rd_ptr_q[grant_idx]];
        ext_data  = {{EXT_W{bus.sign_ext & head_data[DATA_W-1]}}, head_data};
        prio_d    = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                addr_mem_q[i][wr_ptr_q[i]] <= bus.ch_addr[i*ADDR_W +: ADDR_W];
                data_mem_q[i][wr_ptr_q[i]] <= bus.ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            prio_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                count_q[i] <= count_d[i];
            end
            wr_en_q <= grant_vld;
            ovf_q   <= ovf_d;
            if (grant_vld) begin
                prio_q    <= prio_d;
                wr_addr_q <= head_addr;
                wr_data_q <= ext_data;
            end
        end
    end

    assign bus.ch_ready     = ~full;
    assign bus.sram_wr_en   = wr_en_q;
    assign bus.sram_wr_addr = wr_addr_q;
    assign bus.sram_wr_data = wr_data_q;
    assign bus.ovf          = ovf_q;
    assign bus.idle         = ~busy;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_rr_arbiter;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 13;
    localparam int MEM_W  = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int WORD_W = ADDR_W + DATA_W;

    logic clk;
    logic rstn;

    wb_rr_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W)) bus ();

    wb_rr_arbiter #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: one queue of {addr, data} per channel plus the next-priority channel number.
    logic [WORD_W-1:0] fifo_q [NUM_CH][$];
    int                m_prio;
    logic [NUM_CH-1:0] m_ovf;
    logic [NUM_CH-1:0] exp_ready;
    logic              exp_en;
    logic              exp_idle;
    logic [ADDR_W-1:0] exp_addr;
    logic [MEM_W-1:0]  exp_data;

    function automatic logic [MEM_W-1:0] extend(input logic [DATA_W-1:0] d, input logic se);
        int unsigned v;
        v = d;
        if (se && (v >= (1 << (DATA_W - 1)))) v = v + (1 << MEM_W) - (1 << DATA_W);
        return MEM_W'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) fifo_q[i].delete();
        m_prio    = 0;
        m_ovf     = '0;
        exp_en    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_ready = '1;
        exp_idle  = 1'b1;
    endtask

    // Advances the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic [NUM_CH-1:0] rdy;
        int                g;
        logic [WORD_W-1:0] w;
        g = -1;
        for (int i = 0; i < NUM_CH; i++) rdy[i] = (fifo_q[i].size() != DEPTH);
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (m_prio + k) % NUM_CH;
            if (g < 0 && fifo_q[c].size() > 0) g = c;
        end
        exp_en = 1'b0;
        if (g >= 0) begin
            w        = fifo_q[g].pop_front();
            exp_en   = 1'b1;
            exp_addr = w[WORD_W-1:DATA_W];
            exp_data = extend(w[DATA_W-1:0], bus.sign_ext);
            m_prio   = (g + 1) % NUM_CH;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_valid[i] && rdy[i])
                fifo_q[i].push_back({bus.ch_addr[i*ADDR_W +: ADDR_W], bus.ch_data[i*DATA_W +: DATA_W]});
            if (bus.clr_ovf) m_ovf[i] = 1'b0;
            if (bus.ch_valid[i] && !rdy[i]) m_ovf[i] = 1'b1;
        end
        exp_idle = !exp_en;
        for (int i = 0; i < NUM_CH; i++) begin
            exp_ready[i] = (fifo_q[i].size() != DEPTH);
            if (fifo_q[i].size() != 0) exp_idle = 1'b0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ch_valid = '0;
        bus.ch_data  = '0;
        bus.ch_addr  = '0;
        bus.sign_ext = 1'b0;
        bus.clr_ovf  = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.ch_valid[ch]                  = 1'b1;
        bus.ch_addr[ch*ADDR_W +: ADDR_W] = a;
        bus.ch_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        model_reset();
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive_idle();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        model_reset();
        bus.ch_valid = '1;
        @(posedge clk);
        #1;
        checks++; if (bus.sram_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en: got %b want 0", bus.sram_wr_en); end
        checks++; if (bus.sram_wr_addr !== '0) begin failures++; $display("FAIL rst_addr: got %h want 0", bus.sram_wr_addr); end
        checks++; if (bus.sram_wr_data !== '0) begin failures++; $display("FAIL rst_data: got %h want 0", bus.sram_wr_data); end
        checks++; if (bus.ovf !== '0) begin failures++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
        checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL rst_idle: got %b want 1", bus.idle); end
        checks++; if (bus.ch_ready !== '1) begin failures++; $display("FAIL rst_ready: got %b want 1111", bus.ch_ready); end
        bus.ch_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_sign_ext();
        logic [MEM_W-1:0] want;
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            want         = (pass == 0) ? 16'hFFFF : 16'h1FFF;
            bus.sign_ext = (pass == 0);
            set_ch(2, 10'd5, 13'h1FFF);
            tick();
            bus.ch_valid = '0;
            checks++; if (bus.sram_wr_en !== 1'b0) begin failures++; $display("FAIL sext_early: got %b want 0", bus.sram_wr_en); end
            tick();
            checks++;
            if (bus.sram_wr_en !== 1'b1 || bus.sram_wr_addr !== 10'd5 || bus.sram_wr_data !== want) begin
                failures++;
                $display("FAIL sext_write: got en=%b addr=%h data=%h want en=1 addr=005 data=%h",
                         bus.sram_wr_en, bus.sram_wr_addr, bus.sram_wr_data, want);
            end
            checks++;
            if (bus.sram_wr_data !== exp_data) begin
                failures++;
                $display("FAIL sext_model: got %h want %h", bus.sram_wr_data, exp_data);
            end
            tick();
            checks++; if (bus.sram_wr_en !== 1'b0) begin failures++; $display("FAIL sext_one_cycle: got %b want 0", bus.sram_wr_en); end
        end
        drive_idle();
    endtask

    task automatic test_all_push();
        apply_reset();
        for (int i = 0; i < NUM_CH; i++) set_ch(i, ADDR_W'(100 + i), DATA_W'(i * 7 + 1));
        tick();
        drive_idle();
        for (int i = 0; i < NUM_CH; i++) begin
            tick();
            checks++;
            if (bus.sram_wr_en !== 1'b1 || bus.sram_wr_addr !== ADDR_W'(100 + i) ||
                bus.sram_wr_data !== MEM_W'(i * 7 + 1)) begin
                failures++;
                $display("FAIL all_push_order: slot %0d got en=%b addr=%0d data=%0d want en=1 addr=%0d data=%0d",
                         i, bus.sram_wr_en, bus.sram_wr_addr, bus.sram_wr_data, 100 + i, i * 7 + 1);
            end
        end
        tick();
        checks++;
        if (bus.idle !== 1'b1 || bus.sram_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL all_push_idle: got idle=%b en=%b want idle=1 en=0", bus.idle, bus.sram_wr_en);
        end
    endtask

    task automatic test_stream_single();
        int writes;
        writes = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < 5) begin
                checks++;
                if (bus.ch_ready[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL single_ready: cycle %0d got %b want 1", k, bus.ch_ready[1]);
                end
                set_ch(1, ADDR_W'(200 + k), DATA_W'(k));
            end else begin
                drive_idle();
            end
            tick();
            if (bus.sram_wr_en === 1'b1) begin
                checks++;
                if (bus.sram_wr_addr !== ADDR_W'(200 + writes)) begin
                    failures++;
                    $display("FAIL single_addr: got %0d want %0d", bus.sram_wr_addr, 200 + writes);
                end
                writes++;
            end
        end
        checks++; if (writes !== 5) begin failures++; $display("FAIL single_count: got %0d want 5", writes); end
        checks++; if (bus.ovf !== '0) begin failures++; $display("FAIL single_ovf: got %b want 0", bus.ovf); end
    endtask

    task automatic test_all_stream();
        int prev;
        int ch;
        prev = -1;
        apply_reset();
        for (int cyc = 0; cyc < 40; cyc++) begin
            for (int i = 0; i < NUM_CH; i++) set_ch(i, ADDR_W'((i << 8) | (cyc & 255)), DATA_W'($urandom));
            bus.sign_ext = 1'(($urandom));
            tick();
            checks++;
            if ({bus.sram_wr_en, bus.ch_ready, bus.ovf, bus.idle} !== {exp_en, exp_ready, m_ovf, exp_idle}) begin
                failures++;
                $display("FAIL stream_ctrl: got en/rdy/ovf/idle=%b want %b",
                         {bus.sram_wr_en, bus.ch_ready, bus.ovf, bus.idle}, {exp_en, exp_ready, m_ovf, exp_idle});
            end
            checks++;
            if (exp_en && ({bus.sram_wr_addr, bus.sram_wr_data} !== {exp_addr, exp_data})) begin
                failures++;
                $display("FAIL stream_write: got addr=%h data=%h want addr=%h data=%h",
                         bus.sram_wr_addr, bus.sram_wr_data, exp_addr, exp_data);
            end
            if (bus.sram_wr_en === 1'b1) begin
                ch = int'(bus.sram_wr_addr >> 8);
                if (prev >= 0) begin
                    checks++;
                    if (ch !== (prev + 1) % NUM_CH) begin
                        failures++;
                        $display("FAIL stream_rr: got ch%0d want ch%0d", ch, (prev + 1) % NUM_CH);
                    end
                end
                prev = ch;
            end
        end
        checks++; if (bus.ovf !== '1) begin failures++; $display("FAIL stream_ovf: got %b want 1111", bus.ovf); end
        drive_idle();
        for (int n = 0; n < 40 && bus.idle !== 1'b1; n++) begin
            tick();
            checks++;
            if (bus.sram_wr_en !== exp_en || (exp_en && bus.sram_wr_addr !== exp_addr)) begin
                failures++;
                $display("FAIL drain_write: got en=%b addr=%h want en=%b addr=%h",
                         bus.sram_wr_en, bus.sram_wr_addr, exp_en, exp_addr);
            end
        end
        checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL drain_timeout: got idle=%b want 1", bus.idle); end
    endtask

    task automatic test_ovf_clear();
        int n;
        n = 0;
        apply_reset();
        while (bus.ch_ready[3] === 1'b1 && n < 40) begin
            for (int i = 0; i < NUM_CH; i++) set_ch(i, ADDR_W'(n), DATA_W'($urandom));
            tick();
            n++;
        end
        checks++; if (bus.ch_ready[3] !== 1'b0) begin failures++; $display("FAIL ovf_fill_timeout: got ready3=%b want 0", bus.ch_ready[3]); end
        bus.clr_ovf = 1'b1;
        tick();
        checks++; if (bus.ovf[3] !== 1'b1) begin failures++; $display("FAIL ovf_set_wins: got %b want 1", bus.ovf[3]); end
        checks++; if (bus.ovf !== m_ovf) begin failures++; $display("FAIL ovf_model: got %b want %b", bus.ovf, m_ovf); end
        drive_idle();
        bus.clr_ovf = 1'b1;
        tick();
        checks++; if (bus.ovf[3] !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", bus.ovf[3]); end
        checks++; if (bus.ovf !== '0) begin failures++; $display("FAIL ovf_clear_all: got %b want 0000", bus.ovf); end
        bus.clr_ovf = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < NUM_CH; i++) set_ch(i, ADDR_W'(300 + i), DATA_W'(i));
        tick();
        drive_idle();
        tick();
        checks++; if (bus.sram_wr_en !== 1'b1) begin failures++; $display("FAIL mid_pre_write: got %b want 1", bus.sram_wr_en); end
        #2 rstn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.sram_wr_en !== 1'b0 || bus.idle !== 1'b1 || bus.ch_ready !== '1 || bus.sram_wr_addr !== '0) begin
            failures++;
            $display("FAIL mid_async: got en=%b idle=%b rdy=%b addr=%h want en=0 idle=1 rdy=1111 addr=000",
                     bus.sram_wr_en, bus.idle, bus.ch_ready, bus.sram_wr_addr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (bus.sram_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale: cycle %0d got en=%b want 0", k, bus.sram_wr_en);
            end
        end
        set_ch(1, 10'h3AA, 13'h0ABC);
        tick();
        drive_idle();
        tick();
        checks++;
        if (bus.sram_wr_en !== 1'b1 || bus.sram_wr_addr !== 10'h3AA || bus.sram_wr_data !== 16'h0ABC) begin
            failures++;
            $display("FAIL mid_fresh: got en=%b addr=%h data=%h want en=1 addr=3aa data=0abc",
                     bus.sram_wr_en, bus.sram_wr_addr, bus.sram_wr_data);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bus.ch_valid[i]                  = ($urandom_range(0, 9) < 6);
                bus.ch_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                bus.ch_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            bus.sign_ext = 1'($urandom_range(0, 1));
            bus.clr_ovf  = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if ({bus.sram_wr_en, bus.ch_ready, bus.ovf, bus.idle} !== {exp_en, exp_ready, m_ovf, exp_idle}) begin
                failures++;
                $display("FAIL rand_ctrl: cycle %0d got en/rdy/ovf/idle=%b want %b", cyc,
                         {bus.sram_wr_en, bus.ch_ready, bus.ovf, bus.idle}, {exp_en, exp_ready, m_ovf, exp_idle});
            end
            checks++;
            if (exp_en && ({bus.sram_wr_addr, bus.sram_wr_data} !== {exp_addr, exp_data})) begin
                failures++;
                $display("FAIL rand_write: cycle %0d got addr=%h data=%h want addr=%h data=%h", cyc,
                         bus.sram_wr_addr, bus.sram_wr_data, exp_addr, exp_data);
            end
        end
        drive_idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sign_ext();
        test_all_push();
        test_stream_single();
        test_all_stream();
        test_ovf_clear();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of pooling-output channels, 2..8.
REQ-002 SHALL have parameter DATA_W, default 13: channel result width.
REQ-003 SHALL have parameter MEM_W, default 16: SRAM word width, MEM_W > DATA_W.
REQ-004 SHALL have parameter ADDR_W, default 10: SRAM address width.
REQ-005 SHALL have parameter DEPTH, default 4: per-channel FIFO entries, power of two, >= 2.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port ch_valid  input  NUM_CH  per-channel push request.
REQ-009 SHALL have port ch_data  input  NUM_CH*DATA_W  packed results, channel i at [i*DATA_W +: DATA_W].
REQ-010 SHALL have port ch_addr  input  NUM_CH*ADDR_W  packed write addresses, channel i at [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port ch_ready  output  NUM_CH  channel FIFO not full.
REQ-012 SHALL have port sign_ext  input  1  1: sign-extend data to MEM_W; 0: zero-extend.
REQ-013 SHALL have port clr_ovf  input  1  synchronous clear of ovf.
REQ-014 SHALL have port sram_wr_en  output  1  registered SRAM write strobe.
REQ-015 SHALL have port sram_wr_addr  output  ADDR_W  registered SRAM write address.
REQ-016 SHALL have port sram_wr_data  output  MEM_W  registered, extended SRAM write data.
REQ-017 SHALL have port ovf  output  NUM_CH  sticky per-channel dropped-push flag.
REQ-018 SHALL have port idle  output  1  all FIFOs empty and sram_wr_en low.

Function
REQ-019 SHALL keep per channel a DEPTH-entry FIFO of {addr, data} with an occupancy count 0..DEPTH; ch_ready[i] = (count[i] != DEPTH).
REQ-020 SHALL push on an edge where ch_valid[i] & ch_ready[i]; a full FIFO rejects the push even when popped the same edge (no pass-through).
REQ-021 SHALL allow simultaneous push and pop on a non-full FIFO, leaving the count unchanged.
REQ-022 SHALL grant at most one non-empty channel per cycle, round-robin: after a grant to channel k, priority order is k+1, k+2, ... mod NUM_CH; out of reset, channel 0 has highest priority.
REQ-023 SHALL pop the granted head on the edge and register it: sram_wr_en=1, sram_wr_addr=head addr, sram_wr_data=extended head data, valid in the following cycle; sram_wr_en=0 in cycles with no grant.
REQ-024 SHALL give latency: entry pushed on edge N into otherwise-empty FIFOs -> sram_wr_en high in the cycle after edge N+1.
REQ-025 SHALL extend data: upper MEM_W-DATA_W bits = data[DATA_W-1] when sign_ext=1, else 0; sign_ext is sampled at pop.
REQ-026 SHALL set ovf[i] on an edge with ch_valid[i] & !ch_ready[i]; clr_ovf clears all bits; simultaneous set and clear -> set wins for that channel.
REQ-027 SHALL not advance the round-robin pointer in cycles with no grant.
REQ-028 SHALL hold FIFO contents unchanged when neither push nor pop occurs; read/write pointers wrap modulo DEPTH.

Reset
REQ-029 SHALL on rstn low asynchronously clear all counts and pointers, sram_wr_en=0, sram_wr_addr=0, sram_wr_data=0, ovf=0, RR priority to channel 0; idle=1 and ch_ready all 1 while in reset.
REQ-030 SHALL discard all buffered entries when reset asserts mid-operation; first write after release comes only from post-reset pushes.

Verification
REQ-031 SHALL pass: single push ch2 data=13'h1FFF addr=5, sign_ext=1 -> two edges later one cycle sram_wr_en=1, addr=5, data=16'hFFFF; repeat sign_ext=0 -> 16'h1FFF.
REQ-032 SHALL pass: all 4 channels push on same edge -> writes in order ch0, ch1, ch2, ch3 on consecutive cycles, then idle=1.
REQ-033 SHALL pass: ch1 pushes 5 consecutive cycles with no other traffic, DEPTH=4 -> all 5 accepted (pops drain), ovf=0; with ch0..ch3 all streaming every cycle -> ch_ready drops, ovf bits set, each channel granted once per 4 writes.
REQ-034 SHALL pass: ch_valid[3] held while full and clr_ovf pulsed same edge -> ovf[3]=1 afterwards; clr_ovf alone next edge -> ovf[3]=0.
REQ-035 SHALL pass: rstn pulsed low with 3 entries buffered -> sram_wr_en=0 immediately, idle=1, no stale writes after release.
